mem_access_unit: RTL and testbench

//  Memory-stage data access unit of the 5-stage RISC-V core. Sits between the EX/MEM and MEM/WB

---
 rtl/mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage data access unit for the 5-stage RV32I pipeline.
// Launches loads/stores on a valid/ready data-memory port, stalls the front
// of the pipeline while the access is in flight, and hands extended load data
// plus writeback controls to MEM/WB. Non-memory instructions pass straight
// through in the same cycle.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_be,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_rdata,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_rd,
  output logic        access_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // Last count value before the access is abandoned (counter starts at 0).
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tout_q, tout_d;

  logic        mem_op;
  logic        f3_legal;
  logic        misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;
  logic [7:0]  rsp_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);

  // Split the response word into byte lanes for the load extractor.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rsp_byte[gi] = mem_rsp_data[8*gi +: 8];
  end

  // Decode legality and alignment of the incoming EX/MEM access.
  always_comb begin
    f3_legal = 1'b0;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ex_mem_read;
      default:                f3_legal = 1'b0;
    endcase
    misaligned = 1'b0;
    case (ex_funct3[1:0])
      2'b01:   misaligned = ex_addr[0];
      2'b10:   misaligned = |ex_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Place store data into the addressed byte lanes and build the byte enables.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ex_addr[1:0];
        st_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << ex_addr[1:0];
        st_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
      end
    endcase
  end

  // Select and sign/zero-extend the loaded byte/half/word from the response.
  always_comb begin
    sel_byte = rsp_byte[addr_q[1:0]];
    sel_half = addr_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ld_ext = {24'h0, sel_byte};
      3'b001:  ld_ext = {{16{sel_half[15]}}, sel_half};
      3'b101:  ld_ext = {16'h0, sel_half};
      default: ld_ext = mem_rsp_data;
    endcase
  end

  // Request fields come straight from the latched copies so they stay stable in REQ.
  assign mem_req_we    = we_q;
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem_req_wdata = wdata_q;
  assign mem_req_be    = be_q;

  // Next-state, latch updates and pipeline-facing outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    rd_d          = rd_q;
    reg_write_d   = reg_write_q;
    rdata_d       = rdata_q;
    tout_d        = tout_q;
    mem_req_valid = 1'b0;
    stall         = 1'b0;
    wb_valid      = 1'b0;
    wb_reg_write  = 1'b0;
    wb_mem_to_reg = 1'b0;
    wb_rdata      = 32'h0;
    wb_alu_result = 32'h0;
    wb_rd         = 5'h0;
    access_err    = 1'b0;
    timeout_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        wb_valid      = ex_valid;
        wb_reg_write  = ex_reg_write;
        wb_rd         = ex_rd;
        wb_alu_result = ex_addr;
        if (mem_op) begin
          if (f3_legal && !misaligned) begin
            stall        = 1'b1;
            wb_valid     = 1'b0;
            wb_reg_write = 1'b0;
            state_d      = S_REQ;
            cnt_d        = 8'h0;
            addr_d       = ex_addr;
            we_d         = ex_mem_write;
            funct3_d     = ex_funct3;
            rd_d         = ex_rd;
            reg_write_d  = ex_reg_write;
            be_d         = ex_mem_write ? st_be : 4'b1111;
            wdata_d      = ex_mem_write ? st_wdata : 32'h0;
            rdata_d      = 32'h0;
            tout_d       = 1'b0;
          end else begin
            // Faulting access retires immediately without touching memory.
            access_err   = 1'b1;
            wb_reg_write = 1'b0;
          end
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        stall         = 1'b1;
        cnt_d         = cnt_q + 8'h1;
        if (mem_req_ready) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'h1;
        if (mem_rsp_valid) begin
          rdata_d = ld_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          tout_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The instruction still sitting in EX/MEM is the one retiring here.
        wb_valid      = 1'b1;
        wb_mem_to_reg = ~we_q;
        wb_reg_write  = reg_write_q & ~tout_q;
        wb_rdata      = tout_q ? 32'h0 : rdata_q;
        wb_rd         = rd_q;
        wb_alu_result = addr_q;
        timeout_err   = tout_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Everything facing the pipeline and memory is quiet while reset is held.
    if (reset) begin
      mem_req_valid = 1'b0;
      stall         = 1'b0;
      wb_valid      = 1'b0;
      wb_reg_write  = 1'b0;
      wb_mem_to_reg = 1'b0;
      wb_rdata      = 32'h0;
      wb_alu_result = 32'h0;
      wb_rd         = 5'h0;
      access_err    = 1'b0;
      timeout_err   = 1'b0;
    end
  end

  // State, timeout counter and access latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      we_q        <= 1'b0;
      funct3_q    <= 3'h0;
      rd_q        <= 5'h0;
      reg_write_q <= 1'b0;
      rdata_q     <= 32'h0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      rdata_q     <= rdata_d;
      tout_q      <= tout_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, extended loads, faults,
// timeout, reset mid-access and pass-through retire ordering.
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 4;
  localparam logic [31:0] MEM_WORD = 32'h80FF7F01;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        stall, wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [31:0] wb_rdata, wb_alu_result;
  logic [4:0]  wb_rd;
  logic        access_err, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int retire_cnt = 0;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .stall(stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rdata(wb_rdata), .wb_alu_result(wb_alu_result),
    .wb_rd(wb_rd), .access_err(access_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Count retired instructions, sampled mid-cycle.
  always @(negedge clk) begin
    if (wb_valid) retire_cnt <= retire_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input logic rw);
    ex_valid = v; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_rd = rd; ex_reg_write = rw;
  endtask

  task automatic clr_ex();
    set_ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'h0, 1'b0);
  endtask

  // Full load transaction: request accepted in first REQ cycle, response one cycle later.
  task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] exp);
    set_ex(1'b1, 1'b1, 1'b0, f3, a, 32'h0, rd, 1'b1);
    #1;
    check({name, " idle stall"}, 32'(stall), 32'h1);
    check({name, " idle wb_valid"}, 32'(wb_valid), 32'h0);
    tick();
    mem_req_ready = 1'b1;
    #1;
    check({name, " req valid"}, 32'(mem_req_valid), 32'h1);
    check({name, " req addr"}, mem_req_addr, {a[31:2], 2'b00});
    check({name, " req be"}, 32'(mem_req_be), 32'hF);
    check({name, " req we"}, 32'(mem_req_we), 32'h0);
    tick();
    mem_req_ready = 1'b0;
    #1;
    check({name, " wait valid low"}, 32'(mem_req_valid), 32'h0);
    check({name, " wait stall"}, 32'(stall), 32'h1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = MEM_WORD;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    #1;
    check({name, " done wb_valid"}, 32'(wb_valid), 32'h1);
    check({name, " done rdata"}, wb_rdata, exp);
    check({name, " done mem_to_reg"}, 32'(wb_mem_to_reg), 32'h1);
    check({name, " done reg_write"}, 32'(wb_reg_write), 32'h1);
    check({name, " done rd"}, 32'(wb_rd), 32'(rd));
    check({name, " done alu"}, wb_alu_result, a);
    check({name, " done stall"}, 32'(stall), 32'h0);
    $display("txn %s addr=0x%08h rdata=0x%08h", name, a, wb_rdata);
    clr_ex();
    tick();
    #1;
    check({name, " back idle"}, 32'(wb_valid), 32'h0);
  endtask

  // Store whose request is accepted on the first REQ cycle; checks lanes and enables.
  task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    set_ex(1'b1, 1'b0, 1'b1, f3, a, wd, 5'h0, 1'b0);
    tick();
    mem_req_ready = 1'b1;
    #1;
    check({name, " be"}, 32'(mem_req_be), 32'(exp_be));
    check({name, " wdata"}, mem_req_wdata, exp_wd);
    check({name, " we"}, 32'(mem_req_we), 32'h1);
    tick();
    mem_req_ready = 1'b0;
    #1;
    check({name, " done wb_valid"}, 32'(wb_valid), 32'h1);
    $display("txn %s addr=0x%08h be=%b wdata=0x%08h", name, a, exp_be, exp_wd);
    clr_ex();
    tick();
  endtask

  // Faulting access: no request, one-cycle access_err, retires without writing rd.
  task automatic do_fault(input string name, input logic rd_en, input logic [2:0] f3,
                          input logic [31:0] a);
    set_ex(1'b1, rd_en, ~rd_en, f3, a, 32'h1234, 5'd9, rd_en);
    #1;
    check({name, " access_err"}, 32'(access_err), 32'h1);
    check({name, " req valid"}, 32'(mem_req_valid), 32'h0);
    check({name, " stall"}, 32'(stall), 32'h0);
    check({name, " wb_valid"}, 32'(wb_valid), 32'h1);
    check({name, " wb_reg_write"}, 32'(wb_reg_write), 32'h0);
    $display("txn %s addr=0x%08h access_err=%0b", name, a, access_err);
    clr_ex();
    tick();
    #1;
    check({name, " err pulse end"}, 32'(access_err), 32'h0);
    check({name, " req still low"}, 32'(mem_req_valid), 32'h0);
  endtask

  initial begin
    int stall_cycles;
    int r0;

    reset = 1'b1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd3, 1'b1);
    #2;
    check("rst wb_valid", 32'(wb_valid), 32'h0);
    check("rst stall", 32'(stall), 32'h0);
    check("rst req_valid", 32'(mem_req_valid), 32'h0);
    check("rst wb_rd", 32'(wb_rd), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    clr_ex();
    tick();

    // ADD then LW back to back: exactly two retires.
    r0 = retire_cnt;
    set_ex(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
    #1;
    check("add wb_valid", 32'(wb_valid), 32'h1);
    check("add alu", wb_alu_result, 32'h1234);
    check("add rd", 32'(wb_rd), 32'd5);
    check("add reg_write", 32'(wb_reg_write), 32'h1);
    check("add stall", 32'(stall), 32'h0);
    check("add mem_to_reg", 32'(wb_mem_to_reg), 32'h0);
    check("add rdata", wb_rdata, 32'h0);
    $display("txn ADD rd=5 alu=0x%08h", wb_alu_result);
    tick();
    do_load("LW", 3'b010, 32'h200, 5'd7, 32'h80FF7F01);
    check("add+lw retires", 32'(retire_cnt - r0), 32'd2);

    // SW with ready on the second REQ cycle: three stall cycles.
    stall_cycles = 0;
    set_ex(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'h0, 1'b0);
    #1;
    if (stall) stall_cycles++;
    tick();
    #1;
    if (stall) stall_cycles++;
    check("sw req valid", 32'(mem_req_valid), 32'h1);
    check("sw req addr", mem_req_addr, 32'h100);
    check("sw be", 32'(mem_req_be), 32'hF);
    check("sw wdata", mem_req_wdata, 32'hDEADBEEF);
    check("sw we", 32'(mem_req_we), 32'h1);
    tick();
    mem_req_ready = 1'b1;
    #1;
    if (stall) stall_cycles++;
    check("sw req held", 32'(mem_req_valid), 32'h1);
    tick();
    mem_req_ready = 1'b0;
    #1;
    check("sw done stall", 32'(stall), 32'h0);
    check("sw done wb_valid", 32'(wb_valid), 32'h1);
    check("sw done reg_write", 32'(wb_reg_write), 32'h0);
    check("sw done mem_to_reg", 32'(wb_mem_to_reg), 32'h0);
    check("sw stall cycles", 32'(stall_cycles), 32'd3);
    $display("txn SW addr=0x00000100 stall_cycles=%0d", stall_cycles);
    clr_ex();
    tick();

    do_store("SB", 3'b000, 32'h103, 32'h000000AB, 4'b1000, 32'hABABABAB);
    do_store("SH", 3'b001, 32'h102, 32'h0000CAFE, 4'b1100, 32'hCAFECAFE);

    do_load("LB", 3'b000, 32'h203, 5'd10, 32'hFFFFFF80);
    do_load("LBU", 3'b100, 32'h203, 5'd11, 32'h00000080);
    do_load("LH", 3'b001, 32'h202, 5'd12, 32'hFFFF80FF);
    do_load("LHU", 3'b101, 32'h200, 5'd13, 32'h00007F01);

    do_fault("SH-mis", 1'b0, 3'b001, 32'h101);
    do_fault("LW-mis", 1'b1, 3'b010, 32'h202);
    do_fault("L-f3-110", 1'b1, 3'b110, 32'h200);
    do_fault("S-f3-100", 1'b0, 3'b100, 32'h200);

    // Timeout: ready never rises, four REQ cycles then DONE.
    set_ex(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd14, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to req%0d valid", i), 32'(mem_req_valid), 32'h1);
      check($sformatf("to req%0d err", i), 32'(timeout_err), 32'h0);
      tick();
    end
    #1;
    check("to err", 32'(timeout_err), 32'h1);
    check("to req dropped", 32'(mem_req_valid), 32'h0);
    check("to wb_valid", 32'(wb_valid), 32'h1);
    check("to reg_write", 32'(wb_reg_write), 32'h0);
    check("to rdata", wb_rdata, 32'h0);
    check("to stall", 32'(stall), 32'h0);
    $display("txn LW-timeout addr=0x00000200 timeout_err=%0b", timeout_err);
    clr_ex();
    tick();
    #1;
    check("to err pulse end", 32'(timeout_err), 32'h0);
    do_load("LW-after-to", 3'b010, 32'h200, 5'd15, 32'h80FF7F01);

    // Reset while waiting for read data; late response must be ignored.
    set_ex(1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd16, 1'b1);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    r0 = retire_cnt;
    reset = 1'b1;
    #1;
    check("rstw stall", 32'(stall), 32'h0);
    check("rstw wb_valid", 32'(wb_valid), 32'h0);
    tick();
    reset = 1'b0;
    clr_ex();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h12345678;
    #1;
    check("rstw req low", 32'(mem_req_valid), 32'h0);
    check("rstw late stall", 32'(stall), 32'h0);
    check("rstw late wb_valid", 32'(wb_valid), 32'h0);
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    #1;
    check("rstw no done", 32'(wb_valid), 32'h0);
    check("rstw no retire", 32'(retire_cnt - r0), 32'd0);
    $display("txn LW-reset-in-wait retires=%0d", retire_cnt - r0);
    tick();
    do_load("LW-after-rst", 3'b010, 32'h200, 5'd17, 32'h80FF7F01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
